nios_system_button_pio: RTL

NIOS_SYSTEM_BUTTON_PIO -- requirements
Module: nios_system_button_pio

---
 rtl/nios_system_button_pio_pkg.sv | 34 +++
 rtl/nios_system_button_pio_if.sv | 36 +++
 rtl/button_debounce.sv | 56 +++++
 rtl/nios_system_button_pio.sv | 107 ++++++++++
 4 files changed

// File: rtl/nios_system_button_pio_pkg.sv
// ----------------------------------------------------------------------------
// button_pio_pkg
// Shared constants for the button PIO block: Avalon-MM register word
// addresses, edge capture mode encodings, and a per-bit edge qualifier.
// No ports (package).
// ----------------------------------------------------------------------------
package button_pio_pkg;

   // Register word addresses
   localparam logic [1:0] ADDR_DATA    = 2'd0;  // debounced levels, read-only
   localparam logic [1:0] ADDR_RSVD    = 2'd1;  // reserved, reads zero
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;  // interrupt mask, read/write
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;  // edge capture, write-1-to-clear

   // Edge capture modes
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int DATA_W = 32;

   // True when the transition prev -> cur is an edge of the selected kind.
   function automatic logic edge_hit(input int edge_type, input logic cur,
                                     input logic prev);
      logic hit;
      case (edge_type)
         EDGE_RISE: hit = cur & ~prev;
         EDGE_FALL: hit = ~cur & prev;
         default:   hit = cur ^ prev;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/nios_system_button_pio_if.sv
// ----------------------------------------------------------------------------
// nios_system_button_pio_if
// Avalon-MM slave bus of the button PIO plus its interrupt line.
//   address   [1:0]  word address
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] registered read data
//   irq              level interrupt request
// Modports: master (bus host side), slave (button PIO side).
//
// Bus protocol: there is no valid/ready pair. A write is a single-cycle
// strobe that always completes on the rising edge where write is high.
// Reads have no strobe: readdata is registered every cycle from whatever
// address was presented in the previous cycle, so a read is always accepted
// and its data is valid exactly one cycle later, with no side effects.
// ----------------------------------------------------------------------------
interface nios_system_button_pio_if;
   import button_pio_pkg::*;

   logic [1:0]        address;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport master (
      output address, write, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, write, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// One channel of debounce filtering, fed from an already synchronised level.
//   clk         system clock
//   reset_n     synchronous active-low reset
//   sync_level  synchronised raw button level
//   deb_level   debounced level
// Macro BUTTON_PIO_DEBOUNCE_EN: when defined, the debounced level follows
// sync_level only after it has differed for DEBOUNCE_CYCLES consecutive
// cycles. When undefined, deb_level is sync_level and no counter exists.
// ----------------------------------------------------------------------------
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_level,
   output logic deb_level
);

`ifdef BUTTON_PIO_DEBOUNCE_EN

   localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   // cnt holds the number of earlier consecutive cycles the input has
   // differed. For a single bit, any change of the input while it differs
   // makes it equal to deb_level again, so the "equal" branch also covers
   // the restart-on-change case.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= '0;
         deb_level <= 1'b0;
      end else if (sync_level == deb_level) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         deb_level <= sync_level;
         cnt       <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

`else

   assign deb_level = sync_level;

   // Clock, reset and the count parameter have no role without the filter.
   logic unused_ok;
   assign unused_ok = ^{clk, reset_n, 16'(DEBOUNCE_CYCLES)};

`endif

endmodule

// File: rtl/nios_system_button_pio.sv
// ----------------------------------------------------------------------------
// nios_system_button_pio
// Button input PIO with Avalon-MM register access and edge interrupt.
//   clk      system clock (rising edge)
//   reset_n  synchronous active-low reset
//   in_port  [WIDTH-1:0] raw asynchronous button levels
//   avs      Avalon-MM slave (address, write, writedata, readdata, irq)
// Registers: 0 data (RO), 1 reserved, 2 irqmask (RW), 3 edgecapture (W1C).
// Macro BUTTON_PIO_DEBOUNCE_EN enables the per-channel debounce counters;
// without it the debounced level is the synchroniser output.
// ----------------------------------------------------------------------------
module nios_system_button_pio
   import button_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [WIDTH-1:0]        in_port,
   nios_system_button_pio_if.slave avs
);

   logic [WIDTH-1:0]  sync_meta;
   logic [WIDTH-1:0]  sync_level;
   logic [WIDTH-1:0]  deb_level;
   logic [WIDTH-1:0]  prev_level;
   logic [WIDTH-1:0]  edge_det;
   logic [WIDTH-1:0]  clr_mask;
   logic [WIDTH-1:0]  edgecap;
   logic [WIDTH-1:0]  irqmask;
   logic [DATA_W-1:0] rd_mux;
   logic [DATA_W-1:0] readdata_q;
   logic              irq_q;

   // Two-flop synchroniser on every raw input.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_meta  <= '0;
         sync_level <= '0;
      end else begin
         sync_meta  <= in_port;
         sync_level <= sync_meta;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_deb
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk        (clk),
         .reset_n    (reset_n),
         .sync_level (sync_level[g]),
         .deb_level  (deb_level[g])
      );
   end

   always_comb begin
      edge_det = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_det[i] = edge_hit(EDGE_TYPE, deb_level[i], prev_level[i]);
      end
   end

   assign clr_mask = (avs.write && avs.address == ADDR_EDGECAP) ?
                     avs.writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (avs.address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = deb_level;
         ADDR_RSVD:    rd_mux = '0;
         ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // prev_level tracks deb_level even in reset, so release never looks
      // like an edge.
      prev_level <= deb_level;
      if (!reset_n) begin
         edgecap    <= '0;
         irqmask    <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         // Clear first, then set: a coincident edge keeps its bit.
         edgecap <= (edgecap & ~clr_mask) | edge_det;
         if (avs.write && avs.address == ADDR_IRQMASK) begin
            irqmask <= avs.writedata[WIDTH-1:0];
         end
         irq_q      <= |(edgecap & irqmask);
         readdata_q <= rd_mux;
      end
   end

   assign avs.readdata = readdata_q;
   assign avs.irq      = irq_q;

   // Upper writedata bits beyond WIDTH are ignored by every register.
   logic unused_wdata;
   assign unused_wdata = ^avs.writedata;

endmodule
